// File: rtl/step_gen_pkg.sv
// Shared types and default widths for the STEP/DIR pulse generator.
package step_gen_pkg;

    localparam int DEF_COUNT_WIDTH  = 16;
    localparam int DEF_PERIOD_WIDTH = 16;
    localparam int DEF_PULSE_WIDTH  = 4;
    localparam int DEF_DIR_SETUP    = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        DONE  = 3'd4
    } step_state_e;

endpackage

// File: rtl/step_pulse_generator.sv
// Turns queued motion segments into STEP/DIR pin waveforms for one axis.
// All phase timing is counted in tick strobes, never in raw clk cycles.
module step_pulse_generator
    import step_gen_pkg::*;
#(
    parameter int CountWidth  = DEF_COUNT_WIDTH,
    parameter int PeriodWidth = DEF_PERIOD_WIDTH,
    parameter int PulseWidth  = DEF_PULSE_WIDTH,
    parameter int DirSetup    = DEF_DIR_SETUP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    // Handshake: a segment transfers on the rising edge where cmd_valid && cmd_ready;
    // cmd_ready depends only on state, and the offered fields are sampled on that edge.
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [CountWidth-1:0]  cmd_steps,
    input  logic [PeriodWidth-1:0] cmd_period,
    input  logic                   cmd_dir,
    output logic                   step,
    output logic                   dir,
    output logic                   busy,
    output logic                   done,
    output step_state_e            dbg_state
);

    localparam logic [PeriodWidth-1:0] PULSE_TICKS = PeriodWidth'(PulseWidth);
    localparam logic [PeriodWidth-1:0] SETUP_TICKS = PeriodWidth'(DirSetup);
    localparam logic [PeriodWidth-1:0] MIN_PERIOD  = PeriodWidth'(PulseWidth + 1);

    step_state_e            r_state;
    logic [PeriodWidth-1:0] r_cnt;
    logic [PeriodWidth-1:0] r_period;
    logic [CountWidth-1:0]  r_remaining;
    logic                   r_step;
    logic                   r_dir;

    logic                   w_accept;
    logic                   w_phase_end;
    logic [PeriodWidth-1:0] w_period_eff;
    logic [PeriodWidth-1:0] w_low_ticks;

    assign w_accept     = (r_state == IDLE) && cmd_valid;
    assign w_phase_end  = tick && (r_cnt == PeriodWidth'(1));
    // Clamp keeps the LOW phase at one tick or more, so the subtraction cannot wrap.
    assign w_period_eff = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
    assign w_low_ticks  = r_period - PULSE_TICKS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_period    <= '0;
            r_remaining <= '0;
            r_step      <= 1'b0;
            r_dir       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_period    <= w_period_eff;
                        r_remaining <= cmd_steps;
                        r_dir       <= cmd_dir;
                        r_cnt       <= SETUP_TICKS;
                        r_state     <= (cmd_steps == '0) ? DONE : SETUP;
                    end
                end
                SETUP: begin
                    if (w_phase_end) begin
                        r_state     <= HIGH;
                        r_cnt       <= PULSE_TICKS;
                        r_step      <= 1'b1;
                        r_remaining <= r_remaining - CountWidth'(1);
                    end else if (tick) begin
                        r_cnt <= r_cnt - PeriodWidth'(1);
                    end
                end
                HIGH: begin
                    if (w_phase_end) begin
                        r_state <= LOW;
                        r_cnt   <= w_low_ticks;
                        r_step  <= 1'b0;
                    end else if (tick) begin
                        r_cnt <= r_cnt - PeriodWidth'(1);
                    end
                end
                LOW: begin
                    // The last step's LOW phase still runs out, so the next segment
                    // can never place a rising edge closer than one period.
                    if (w_phase_end) begin
                        if (r_remaining == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_state     <= HIGH;
                            r_cnt       <= PULSE_TICKS;
                            r_step      <= 1'b1;
                            r_remaining <= r_remaining - CountWidth'(1);
                        end
                    end else if (tick) begin
                        r_cnt <= r_cnt - PeriodWidth'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_step  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign step      = r_step;
    assign dir       = r_dir;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_step_pulse_generator.sv
// Directed bench for step_pulse_generator: edge timing measured in ticks and clk cycles.
module tb_step_pulse_generator;
    import step_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_steps = '0;
    logic [15:0] cmd_period = '0;
    logic        cmd_dir = 1'b0;
    logic        step;
    logic        dir;
    logic        busy;
    logic        done;
    step_state_e dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic tick_en = 1'b0;
    int   tick_div = 10;
    int   tick_ph = 0;

    // monitor bookkeeping
    int   tick_cnt = 0;
    int   dir_chg_tick = 0;
    logic prev_step = 1'b0;
    logic prev_dir = 1'b0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   rise_tick[$];
    int   rise_cyc[$];
    int   rise_setup[$];
    logic rise_dir[$];
    int   fall_tick[$];
    int   fall_cyc[$];

    step_pulse_generator #(
        .CountWidth (16),
        .PeriodWidth(16),
        .PulseWidth (4),
        .DirSetup   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_steps (cmd_steps),
        .cmd_period(cmd_period),
        .cmd_dir   (cmd_dir),
        .step      (step),
        .dir       (dir),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset / tick source ----------------
    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tick_en && tick_ph >= tick_div - 1) begin
                tick    = 1'b1;
                tick_ph = 0;
            end else begin
                tick = 1'b0;
                if (tick_en) tick_ph++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- edge monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_step = 1'b0;
            prev_dir  = 1'b0;
        end else begin
            if (dir !== prev_dir) dir_chg_tick = tick_cnt;
            if (step && !prev_step) begin
                rise_tick.push_back(tick_cnt);
                rise_cyc.push_back(cyc);
                rise_dir.push_back(dir);
                rise_setup.push_back(tick_cnt - dir_chg_tick);
            end
            if (!step && prev_step) begin
                fall_tick.push_back(tick_cnt);
                fall_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (tick) tick_cnt++;
            prev_step = step;
            prev_dir  = dir;
        end
    end

    // ---------------- checker and driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offers a segment and returns the cycle number of the accept cycle; cmd_valid stays high.
    task automatic send(input logic [15:0] s, input logic [15:0] p, input logic d,
                        input string tag, output int acc);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_steps  = s;
        cmd_period = p;
        cmd_dir    = d;
        for (int i = 0; i < 3000; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_accept_timeout"}, ok, 1);
        acc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_done_timeout"}, ok, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int acc_a;
        int acc_b;
        int rb;
        int db;
        int dcb;
        bit ok;

        repeat (3) @(negedge clk);
        check("rst_step", step, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        // idle after reset: 100 cycles with no command
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_step", step, 0);
            check("idle_dir", dir, 0);
            check("idle_ready", cmd_ready, 1);
            check("idle_busy", busy, 0);
        end
        check("idle_state", dbg_state, IDLE);

        // 3 steps, period 8 ticks, tick every 10 clk
        tick_div = 10;
        tick_en  = 1'b1;
        rb  = rise_cyc.size();
        db  = fall_cyc.size();
        dcb = done_cnt;
        send(16'd3, 16'd8, 1'b1, "seg3", acc_a);
        cmd_valid = 1'b0;
        wait_done("seg3");
        @(negedge clk);
        check("seg3_ready_after", cmd_ready, 1);
        check("seg3_busy_after", busy, 0);
        check("seg3_done_1cyc", done, 0);
        check("seg3_rises", rise_cyc.size() - rb, 3);
        check("seg3_falls", fall_cyc.size() - db, 3);
        check("seg3_done_count", done_cnt - dcb, 1);
        if (rise_cyc.size() - rb == 3 && fall_cyc.size() - db == 3) begin
            check("seg3_dir_setup_ticks", rise_setup[rb], 2);
            for (int i = 0; i < 3; i++) begin
                check("seg3_dir_at_rise", rise_dir[rb+i], 1);
                check("seg3_high_clk", fall_cyc[db+i] - rise_cyc[rb+i], 40);
                check("seg3_high_ticks", fall_tick[db+i] - rise_tick[rb+i], 4);
            end
            for (int i = 1; i < 3; i++) begin
                check("seg3_rise_spacing_clk", rise_cyc[rb+i] - rise_cyc[rb+i-1], 80);
                check("seg3_rise_spacing_ticks", rise_tick[rb+i] - rise_tick[rb+i-1], 8);
            end
        end

        // zero-step segments: done the cycle after accept, DIR still follows
        rb  = rise_cyc.size();
        dcb = done_cnt;
        send(16'd0, 16'd8, 1'b0, "zero_d0", acc_a);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("zero_d0_done", done, 1);
        check("zero_d0_dir", dir, 0);
        check("zero_d0_step", step, 0);
        send(16'd0, 16'd8, 1'b1, "zero_d1", acc_a);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("zero_d1_done", done, 1);
        check("zero_d1_dir", dir, 1);
        @(negedge clk);
        check("zero_d1_done_gone", done, 0);
        check("zero_d1_ready", cmd_ready, 1);
        repeat (20) @(negedge clk);
        check("zero_no_rises", rise_cyc.size() - rb, 0);
        check("zero_done_count", done_cnt - dcb, 2);

        // period below PulseWidth+1 is clamped to 5 ticks
        tick_div = 3;
        rb = rise_tick.size();
        db = fall_tick.size();
        send(16'd3, 16'd2, 1'b0, "clamp", acc_a);
        cmd_valid = 1'b0;
        wait_done("clamp");
        repeat (2) @(negedge clk);
        check("clamp_rises", rise_tick.size() - rb, 3);
        check("clamp_falls", fall_tick.size() - db, 3);
        if (rise_tick.size() - rb == 3 && fall_tick.size() - db == 3) begin
            check("clamp_dir_setup_ticks", rise_setup[rb], 2);
            for (int i = 0; i < 3; i++)
                check("clamp_high_ticks", fall_tick[db+i] - rise_tick[rb+i], 4);
            for (int i = 1; i < 3; i++) begin
                check("clamp_low_ticks", rise_tick[rb+i] - fall_tick[db+i-1], 1);
                check("clamp_spacing_ticks", rise_tick[rb+i] - rise_tick[rb+i-1], 5);
            end
        end

        // back-to-back: A (2 steps, P=6, dir 0) then B (1 step, dir 1), valid held
        tick_div = 10;
        rb  = rise_tick.size();
        dcb = done_cnt;
        send(16'd2, 16'd6, 1'b0, "b2b_a", acc_a);
        send(16'd1, 16'd6, 1'b1, "b2b_b", acc_b);
        check("b2b_a_done_seen", done_cnt - dcb, 1);
        check("b2b_b_accept_after_done", acc_b, done_cyc + 1);
        cmd_valid = 1'b0;
        wait_done("b2b_b");
        repeat (2) @(negedge clk);
        check("b2b_rises", rise_tick.size() - rb, 3);
        check("b2b_done_count", done_cnt - dcb, 2);
        if (rise_tick.size() - rb == 3) begin
            check("b2b_a_spacing", rise_tick[rb+1] - rise_tick[rb], 6);
            check("b2b_a_dir", rise_dir[rb], 0);
            check("b2b_b_dir", rise_dir[rb+2], 1);
            check("b2b_b_dir_setup", rise_setup[rb+2], 2);
            check("b2b_gap_ge_period", (rise_tick[rb+2] - rise_tick[rb+1]) >= 6, 1);
        end

        // asynchronous reset while STEP is high
        tick_div = 3;
        dcb = done_cnt;
        send(16'd5, 16'd8, 1'b1, "rstmid", acc_a);
        cmd_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (step) begin
                ok = 1'b1;
                break;
            end
        end
        check("rstmid_step_seen", ok, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_step_async", step, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_state", dbg_state, IDLE);
        check("rstmid_done", done, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("rstmid_post_step", step, 0);
            check("rstmid_post_ready", cmd_ready, 1);
        end
        check("rstmid_no_done", done_cnt - dcb, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
